// File: rtl/uart_echo_fifo_pkg.sv
// Shared defaults and send-FSM encoding for the UART echo FIFO.
package uart_echo_fifo_pkg;
   localparam int FIFO_DEPTH_DEF   = 8;
   localparam int ADDR_WIDTH_DEF   = 3;
   localparam int BUSY_TIMEOUT_DEF = 16;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      LOAD      = ST_LOAD,
      START     = ST_START,
      WAIT_BUSY = ST_WAIT_BUSY,
      WAIT_DONE = ST_WAIT_DONE
   } state_t;
endpackage

// File: rtl/uart_echo_fifo_if.sv
// RX/TX and status bundle between the echo FIFO and its UART neighbours.
interface uart_echo_fifo_if
   import uart_echo_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
   logic [7:0]          rx_data;
   logic                rx_done;
   logic                tx_busy;
   logic                ovf_clr;
   logic [7:0]          tx_data;
   logic                send_en;
   logic [ADDR_WIDTH:0] fifo_count;
   logic                fifo_empty;
   logic                fifo_full;
   logic                overflow;

   modport master (
      input  rx_data, rx_done, tx_busy, ovf_clr,
      output tx_data, send_en, fifo_count,
      output fifo_empty, fifo_full, overflow
   );

   modport slave (
      output rx_data, rx_done, tx_busy, ovf_clr,
      input  tx_data, send_en, fifo_count,
      input  fifo_empty, fifo_full, overflow
   );
endinterface

// File: rtl/uart_echo_fifo_fifo.sv
// Circular byte FIFO with extra pointer MSB and sticky overflow flag.
module sync_byte_fifo
   import uart_echo_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic                ovf_clr,
   input  logic [7:0]          din,
   output logic [7:0]          dout,
   output logic [ADDR_WIDTH:0] count,
   output logic                empty,
   output logic                full,
   output logic                overflow
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_n;
   logic [PW-1:0] rd_ptr_n;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = count == PW'(FIFO_DEPTH);
   assign empty = count == '0;

   // full is judged before any same-cycle read
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   assign wr_ptr_n = wr_ptr + PW'(wr_ok);
   assign rd_ptr_n = rd_ptr + PW'(rd_ok);
   assign dout     = mem[rd_ptr[ADDR_WIDTH-1:0]];

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         count  <= wr_ptr_n - rd_ptr_n;
         if (wr_en && full)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_echo_fifo.sv
// RX-to-TX loopback: edge-detected capture into a FIFO, paced send FSM.
module uart_echo_fifo
   import uart_echo_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input logic clk,
   input logic reset_n,
   uart_echo_fifo_if.master bus
);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   state_t        state;
   state_t        state_n;
   logic          rx_done_d;
   logic          wr_en;
   logic          rd_en;
   logic          empty;
   logic [7:0]    dout;
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_n;

   assign wr_en = bus.rx_done && !rx_done_d;

   sync_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .ovf_clr  (bus.ovf_clr),
      .din      (bus.rx_data),
      .dout     (dout),
      .count    (bus.fifo_count),
      .empty    (empty),
      .full     (bus.fifo_full),
      .overflow (bus.overflow)
   );

   assign bus.fifo_empty = empty;

   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      rd_en   = 1'b0;
      unique case (state)
         IDLE:
            if (!empty && !bus.tx_busy)
               state_n = LOAD;
         LOAD: begin
            rd_en   = 1'b1;
            state_n = START;
         end
         START: begin
            tmr_n   = '0;
            state_n = WAIT_BUSY;
         end
         // a transmitter that never reports busy still releases the FSM
         WAIT_BUSY:
            if (bus.tx_busy)
               state_n = WAIT_DONE;
            else if (tmr == TW'(BUSY_TIMEOUT - 1))
               state_n = IDLE;
            else
               tmr_n = tmr + TW'(1);
         WAIT_DONE:
            if (!bus.tx_busy)
               state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tmr         <= '0;
         rx_done_d   <= 1'b0;
         bus.send_en <= 1'b0;
         bus.tx_data <= '0;
      end else begin
         state       <= state_n;
         tmr         <= tmr_n;
         rx_done_d   <= bus.rx_done;
         bus.send_en <= state_n == START;
         if (rd_en)
            bus.tx_data <= dout;
      end
   end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo with a simple TX busy model.
module tb_uart_echo_fifo;
   import uart_echo_fifo_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uart_echo_fifo_if #(.ADDR_WIDTH(3)) ifc ();

   bit hold_busy;
   bit model_busy;
   int busy_len;
   assign ifc.tx_busy = hold_busy | model_busy;

   uart_echo_fifo #(
      .FIFO_DEPTH   (8),
      .ADDR_WIDTH   (3),
      .BUSY_TIMEOUT (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_send = 0;
   int cyc = 0;
   bit prev_send = 1'b0;
   byte unsigned exp_q[$];
   int send_cyc[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_byte(input logic [7:0] b, input int hold = 1);
      ifc.rx_data = b;
      ifc.rx_done = 1'b1;
      step(hold);
      ifc.rx_done = 1'b0;
      step(1);
   endtask

   task automatic wait_drain(input string nm, input int bound);
      int k = 0;
      while ((exp_q.size() != 0 || !ifc.fifo_empty) && k < bound) begin
         step(1);
         k++;
      end
      chk({nm, "_drained_in_time"}, int'(k < bound), 1);
      step(40);
      chk({nm, "_count_zero"}, int'(ifc.fifo_count), 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      model_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.send_en && busy_len > 0) begin
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 model_busy = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         prev_send = 1'b0;
      end else begin
         if (ifc.send_en) begin
            n_send++;
            send_cyc.push_back(cyc);
            chk("send_while_busy", int'(ifc.tx_busy), 0);
            chk("send_en_pulse", int'(prev_send), 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_send: got tx_data 0x%0h, required no send",
                        ifc.tx_data);
            end else begin
               chk("tx_data", int'(ifc.tx_data), int'(exp_q.pop_front()));
            end
         end
         prev_send = ifc.send_en;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int s0;
      int k;
      ifc.rx_data = '0;
      ifc.rx_done = 1'b0;
      ifc.ovf_clr = 1'b0;
      hold_busy = 1'b0;
      busy_len = 0;
      step(3);
      chk("rst_count", int'(ifc.fifo_count), 0);
      chk("rst_empty", int'(ifc.fifo_empty), 1);
      chk("rst_full", int'(ifc.fifo_full), 0);
      chk("rst_ovf", int'(ifc.overflow), 0);
      chk("rst_send_en", int'(ifc.send_en), 0);
      chk("rst_tx_data", int'(ifc.tx_data), 0);
      reset_n = 1'b1;
      step(2);

      busy_len = 100;
      lat = 0;
      ifc.rx_data = 8'hA5;
      ifc.rx_done = 1'b1;
      exp_q.push_back(8'hA5);
      for (int i = 1; i <= 6; i++) begin
         step(1);
         if (i == 1) begin
            ifc.rx_done = 1'b0;
            chk("single_count", int'(ifc.fifo_count), 1);
         end
         if (ifc.send_en && lat == 0)
            lat = i;
      end
      chk("single_latency", lat, 3);
      wait_drain("single", 300);
      chk("single_empty", int'(ifc.fifo_empty), 1);

      hold_busy = 1'b1;
      s0 = n_send;
      for (int i = 1; i <= 5; i++) begin
         rx_byte(8'(i));
         exp_q.push_back(8'(i));
         step(18);
      end
      chk("burst_count", int'(ifc.fifo_count), 5);
      busy_len = 6;
      hold_busy = 1'b0;
      wait_drain("burst", 400);
      chk("burst_sends", n_send - s0, 5);

      hold_busy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rx_byte(8'h30 + 8'(i));
         if (i < 8)
            exp_q.push_back(8'h30 + 8'(i));
      end
      chk("ovf_count", int'(ifc.fifo_count), 8);
      chk("ovf_full", int'(ifc.fifo_full), 1);
      chk("ovf_flag", int'(ifc.overflow), 1);
      ifc.rx_data = 8'h3F;
      ifc.rx_done = 1'b1;
      ifc.ovf_clr = 1'b1;
      step(1);
      ifc.rx_done = 1'b0;
      ifc.ovf_clr = 1'b0;
      chk("ovf_set_wins", int'(ifc.overflow), 1);
      chk("ovf_count_held", int'(ifc.fifo_count), 8);
      step(1);
      ifc.ovf_clr = 1'b1;
      step(1);
      ifc.ovf_clr = 1'b0;
      chk("ovf_cleared", int'(ifc.overflow), 0);
      hold_busy = 1'b0;
      wait_drain("ovf", 600);

      busy_len = 0;
      s0 = send_cyc.size();
      rx_byte(8'h55);
      exp_q.push_back(8'h55);
      rx_byte(8'h66);
      exp_q.push_back(8'h66);
      wait_drain("timeout", 300);
      chk("timeout_sends", send_cyc.size() - s0, 2);
      if (send_cyc.size() >= s0 + 2)
         chk("timeout_gap", send_cyc[s0+1] - send_cyc[s0], 19);

      hold_busy = 1'b1;
      rx_byte(8'h77, 5);
      exp_q.push_back(8'h77);
      step(3);
      chk("level_count", int'(ifc.fifo_count), 1);
      busy_len = 4;
      hold_busy = 1'b0;
      wait_drain("level", 200);

      for (int i = 0; i < 20; i++) begin
         k = 0;
         while (ifc.fifo_full && k < 500) begin
            step(1);
            k++;
         end
         busy_len = int'($urandom_range(1, 8));
         rx_byte(8'h10 + 8'(i));
         exp_q.push_back(8'h10 + 8'(i));
         step(int'($urandom_range(0, 10)));
      end
      wait_drain("wrap", 1000);

      busy_len = 40;
      rx_byte(8'hC1);
      exp_q.push_back(8'hC1);
      rx_byte(8'hC2);
      rx_byte(8'hC3);
      step(8);
      chk("mid_count", int'(ifc.fifo_count), 2);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_count", int'(ifc.fifo_count), 0);
      chk("arst_empty", int'(ifc.fifo_empty), 1);
      chk("arst_full", int'(ifc.fifo_full), 0);
      chk("arst_ovf", int'(ifc.overflow), 0);
      chk("arst_send_en", int'(ifc.send_en), 0);
      chk("arst_tx_data", int'(ifc.tx_data), 0);
      @(negedge clk);
      s0 = n_send;
      reset_n = 1'b1;
      step(80);
      chk("post_rst_no_send", n_send - s0, 0);
      chk("post_rst_count", int'(ifc.fifo_count), 0);
      rx_byte(8'hD4);
      exp_q.push_back(8'hD4);
      wait_drain("post_rst", 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Loopback buffer between the UART receive and transmit paths of uart_top.
- Captures each received byte (rcv_data qualified by recv_done) into a circular FIFO.
- Drains the FIFO one byte at a time into the transmitter, driving send_data/send_en and pacing on the transmitter busy state.
- Decouples bursty RX from TX so back-to-back received bytes are not lost while TX is busy.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; must be a power of 2.
- ADDR_WIDTH, 3, log2(FIFO_DEPTH).
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after send_en before treating the byte as sent.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; connects to uart_top rcv_data.
- rx_done  in  1  receive-complete strobe; connects to uart_top recv_done.
- tx_busy  in  1  transmitter state; high while a byte is being sent. Connects to uart_top uart_idle, which carries the TX state and is high = busy.
- tx_data  out  8  byte to send; connects to uart_top send_data.
- send_en  out  1  one-cycle start pulse; connects to uart_top send_en.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- fifo_empty  out  1  high when fifo_count == 0.
- fifo_full  out  1  high when fifo_count == FIFO_DEPTH.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: all outputs 0 except fifo_empty = 1. Pointers and count are 0, FSM is in IDLE, rx_done_d is 0. FIFO memory contents are not reset.
- Write:
  - rx_done is edge-detected via a registered rx_done_d.
  - A write occurs on the clock edge where rx_done = 1 and rx_done_d = 0, so a multi-cycle level still produces exactly one write.
  - mem[wr_ptr] <= rx_data and wr_ptr increments, wrapping modulo FIFO_DEPTH.
- Full: a write request while fifo_full drops the byte and sets overflow. Pointers and count are unchanged.
- overflow is cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins.
- Pointers are ADDR_WIDTH+1 bits wide; the MSB distinguishes full from empty on wrap.
- fifo_count = wr_ptr - rd_ptr (modulo 2^(ADDR_WIDTH+1)), held in a register.
- A simultaneous write and read in the same cycle are both performed and count is unchanged. A write while full in the same cycle as a read is still dropped, because full is evaluated before the read.
- Send FSM (registered state):
  - IDLE: if !fifo_empty && !tx_busy, go to LOAD.
  - LOAD: tx_data <= mem[rd_ptr[ADDR_WIDTH-1:0]]; rd_ptr++; go to START.
  - START: send_en = 1 for exactly this cycle; go to WAIT_BUSY; timeout counter cleared.
  - WAIT_BUSY: if tx_busy = 1, go to WAIT_DONE. If the counter reaches BUSY_TIMEOUT-1 without tx_busy, go to IDLE (byte is considered sent, no retry).
  - WAIT_DONE: when tx_busy = 0, go to IDLE.
- tx_data is held stable from the LOAD edge until the next LOAD.
- send_en is a registered output, high only in START, and never high on two consecutive cycles.
- Latency: rx_done rises in cycle N → count = 1 in N+1 → LOAD in N+2 → send_en high in N+3.
- Back-to-back bytes: the next LOAD cannot occur before tx_busy has fallen and the FSM has returned to IDLE.
- Reset mid-operation flushes the FIFO: any queued bytes are lost and no send_en is issued after reset release until a new rx_done edge.
- tx_busy high while in IDLE blocks LOAD. This covers an external sender owning the transmitter.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 0, LOAD = 1, START = 2, WAIT_BUSY = 3, WAIT_DONE = 4; 3-bit localparams.
  - Default FIFO_DEPTH and ADDR_WIDTH.
- One sub-module is natural: sync_byte_fifo. It contains the memory, pointers, count, full/empty and overflow logic, with wr_en/rd_en/din/dout.
- The top module holds the rx_done edge detect and the send FSM.

Test Plan:
- Single byte: rx_data = 8'hA5 with a one-cycle rx_done at cycle 10 → fifo_count = 1 at cycle 11; send_en is a one-cycle pulse at cycle 13 with tx_data = 8'hA5; the bench models tx_busy high for 100 cycles starting at cycle 14; FIFO empty afterwards.
- Burst order: rx bytes 8'h01..8'h05 at 20-cycle spacing while tx_busy is held high → count reaches 5; after tx_busy releases, bytes are sent in order 01,02,03,04,05, one send_en per byte, each only after tx_busy has fallen.
- Overflow: 9 writes with tx_busy held high → count = 8, fifo_full = 1, overflow = 1, and the 9th byte is absent from the output. Pulsing ovf_clr clears overflow.
- Wrap-around: 20 bytes 8'h10..8'h23 pushed and drained at random interleave → output sequence is exactly 10..23, and count returns to 0.
- Timeout and level strobe:
  - tx_busy tied low → send_en pulses, the FSM returns to IDLE 16 cycles later, and the next byte is sent.
  - rx_done held high for 5 cycles → exactly one write.
- Reset mid-transfer: 3 bytes queued and the FSM in WAIT_DONE; assert reset_n low asynchronously → outputs return to reset values immediately; after release, no send_en until a new rx_done.
